// File: rtl/atm_auth_engine_pkg.sv
// Shared types and helpers for the ATM account authenticator.
package atm_auth_pkg;

  localparam logic ACT_FIND         = 1'b0;
  localparam logic ACT_AUTHENTICATE = 1'b1;

  typedef enum logic [1:0] {IDLE, SEARCH, RESPOND} state_t;

  // Minimum one bit, so a single-value range still gets a usable vector.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/atm_auth_engine_if.sv
// Request/response, table-write and session signals of the authenticator.
interface atm_auth_engine_if #(
  parameter int ACC_W = 12,
  parameter int PIN_W = 4,
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_action;
  logic [ACC_W-1:0] req_acc;
  logic [PIN_W-1:0] req_pin;
  logic             rsp_valid;
  logic             rsp_success;
  logic [IDX_W-1:0] rsp_index;
  logic             rsp_locked;
  logic             db_we;
  logic [IDX_W-1:0] db_addr;
  logic [ACC_W-1:0] db_acc;
  logic [PIN_W-1:0] db_pin;
  logic             db_err;
  logic             de_auth;
  logic             session_active;
  logic [IDX_W-1:0] session_index;

  modport master (
    output req_valid, req_action, req_acc, req_pin, db_we, db_addr, db_acc, db_pin, de_auth,
    input  req_ready, rsp_valid, rsp_success, rsp_index, rsp_locked, db_err,
           session_active, session_index
  );

  modport slave (
    input  req_valid, req_action, req_acc, req_pin, db_we, db_addr, db_acc, db_pin, de_auth,
    output req_ready, rsp_valid, rsp_success, rsp_index, rsp_locked, db_err,
           session_active, session_index
  );
endinterface

// File: rtl/atm_auth_engine_table.sv
// Account table: acc/pin storage plus valid, lock and fail-counter state per entry.
// Combinational read at rd_idx; write and counter/lock update take effect next edge.
module atm_account_table #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 12,
  parameter int PIN_W        = 4,
  parameter int IDX_W        = 4,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [ACC_W-1:0] wr_acc,
  input  logic [PIN_W-1:0] wr_pin,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [ACC_W-1:0] rd_acc,
  output logic [PIN_W-1:0] rd_pin,
  output logic             rd_lock,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             upd_en,
  input  logic [CNT_W-1:0] upd_cnt,
  input  logic             upd_lock
);

  logic [ACC_W-1:0]    acc_mem [NUM_ACCOUNTS];
  logic [PIN_W-1:0]    pin_mem [NUM_ACCOUNTS];
  logic [CNT_W-1:0]    cnt_q   [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] valid_q;
  logic [NUM_ACCOUNTS-1:0] lock_q;

  // Contents are meaningless until the valid bit is set, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      acc_mem[wr_addr] <= wr_acc;
      pin_mem[wr_addr] <= wr_pin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lock_q  <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) cnt_q[i] <= '0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
      lock_q[wr_addr]  <= 1'b0;
      cnt_q[wr_addr]   <= '0;
    end else if (upd_en) begin
      lock_q[rd_idx] <= upd_lock;
      cnt_q[rd_idx]  <= upd_cnt;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_acc   = acc_mem[rd_idx];
  assign rd_pin   = pin_mem[rd_idx];
  assign rd_lock  = lock_q[rd_idx];
  assign rd_cnt   = cnt_q[rd_idx];

endmodule

// File: rtl/atm_auth_engine.sv
// Account FIND/AUTHENTICATE engine with wrong-PIN lockout and one open session.
// Linear search, one entry per cycle: response 2+k cycles after accept, or 1+NUM_ACCOUNTS on miss.
// req_ready only in IDLE with no table write pending; one request in flight at a time.
module atm_auth_engine
  import atm_auth_pkg::*;
#(
  parameter int  NUM_ACCOUNTS = 10,
  parameter int  ACC_W        = 12,
  parameter int  PIN_W        = 4,
  parameter int  MAX_TRIES    = 3,
  localparam int IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input logic              clk,
  input logic              rst,
  atm_auth_engine_if.slave bus
);

  localparam int CNT_W = width_of(MAX_TRIES + 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             act_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;

  logic             rd_valid, rd_lock;
  logic [ACC_W-1:0] rd_acc;
  logic [PIN_W-1:0] rd_pin;
  logic [CNT_W-1:0] rd_cnt, cnt_next, upd_cnt;
  logic             addr_ok, wr_en, accept, hit, last, pin_ok, auth_upd, upd_lock;

  assign addr_ok       = {1'b0, bus.db_addr} < (IDX_W+1)'(NUM_ACCOUNTS);
  assign wr_en         = bus.db_we && (state == IDLE) && addr_ok;
  assign bus.req_ready = (state == IDLE) && !bus.db_we && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  assign hit      = (state == SEARCH) && rd_valid && (rd_acc == acc_q);
  assign last     = (ptr == IDX_W'(NUM_ACCOUNTS - 1));
  assign pin_ok   = (rd_pin == pin_q);
  assign cnt_next = (rd_cnt >= CNT_W'(MAX_TRIES)) ? CNT_W'(MAX_TRIES) : rd_cnt + CNT_W'(1);
  assign upd_cnt  = pin_ok ? '0 : cnt_next;
  assign upd_lock = !pin_ok && (cnt_next == CNT_W'(MAX_TRIES));
  // Locked entries are frozen: only an admin rewrite touches them.
  assign auth_upd = hit && (act_q == ACT_AUTHENTICATE) && !rd_lock;

  atm_account_table #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (bus.db_addr),
    .wr_acc  (bus.db_acc),
    .wr_pin  (bus.db_pin),
    .rd_idx  (ptr),
    .rd_valid(rd_valid),
    .rd_acc  (rd_acc),
    .rd_pin  (rd_pin),
    .rd_lock (rd_lock),
    .rd_cnt  (rd_cnt),
    .upd_en  (auth_upd),
    .upd_cnt (upd_cnt),
    .upd_lock(upd_lock)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      ptr                <= '0;
      act_q              <= 1'b0;
      acc_q              <= '0;
      pin_q              <= '0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_success    <= 1'b0;
      bus.rsp_index      <= '0;
      bus.rsp_locked     <= 1'b0;
      bus.db_err         <= 1'b0;
      bus.session_active <= 1'b0;
      bus.session_index  <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.db_err    <= bus.db_we && ((state != IDLE) || !addr_ok);

      case (state)
        IDLE: begin
          if (accept) begin
            state <= SEARCH;
            ptr   <= '0;
            act_q <= bus.req_action;
            acc_q <= bus.req_acc;
            pin_q <= bus.req_pin;
          end
        end
        SEARCH: begin
          if (hit) begin
            state         <= RESPOND;
            bus.rsp_valid <= 1'b1;
            bus.rsp_index <= ptr;
            if (act_q == ACT_FIND) begin
              bus.rsp_success <= 1'b1;
              bus.rsp_locked  <= rd_lock;
            end else if (rd_lock) begin
              bus.rsp_success <= 1'b0;
              bus.rsp_locked  <= 1'b1;
            end else begin
              bus.rsp_success <= pin_ok;
              bus.rsp_locked  <= upd_lock;
            end
          end else if (last) begin
            state           <= RESPOND;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_success <= 1'b0;
            bus.rsp_index   <= '0;
            bus.rsp_locked  <= 1'b0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (auth_upd && pin_ok) begin
        bus.session_active <= 1'b1;
        bus.session_index  <= ptr;
      end
      // Clears come last so de_auth beats a same-edge successful login.
      if ((accept && bus.req_action == ACT_AUTHENTICATE) || bus.de_auth ||
          (wr_en && bus.session_active && bus.db_addr == bus.session_index)) begin
        bus.session_active <= 1'b0;
        bus.session_index  <= '0;
      end
    end
  end

endmodule
